// File: rtl/vga_sync_gen.sv
// vga_sync_gen: registered VGA raster timing (position, visible flag, strobes, sync levels).
// Outputs decode the post-advance counter value, so every output describes the same pixel.
module vga_sync_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_visible,
  output logic       o_line_strobe,
  output logic       o_frame_strobe,
  output logic       o_hsync,
  output logic       o_vsync
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hpos_q, vpos_q;
  logic       vis_q, line_q, frame_q, hsync_q, vsync_q;
  always_comb begin
    hcnt_d = (hcnt_q == H_MAX) ? '0 : hcnt_q + 10'd1;
    vcnt_d = (hcnt_q != H_MAX) ? vcnt_q : (vcnt_q == V_MAX) ? '0 : vcnt_q + 10'd1;
  end
  // Counters reset to the last pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hcnt_q  <= H_MAX;
      vcnt_q  <= V_MAX;
      hpos_q  <= '0;
      vpos_q  <= '0;
      vis_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
    end else if (i_enable) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hpos_q  <= hcnt_d;
      vpos_q  <= vcnt_d;
      vis_q   <= (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
      line_q  <= (hcnt_d == '0);
      frame_q <= (hcnt_d == '0) && (vcnt_d == V_VIS);
      hsync_q <= (hcnt_d >= HS_BEG && hcnt_d < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q <= (vcnt_d >= VS_BEG && vcnt_d < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end
  assign o_hpos         = hpos_q;
  assign o_vpos         = vpos_q;
  assign o_visible      = vis_q;
  assign o_line_strobe  = line_q;
  assign o_frame_strobe = frame_q;
  assign o_hsync        = hsync_q;
  assign o_vsync        = vsync_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size DUT (sync active low) plus a tiny-timing DUT (sync active high),
// both checked every cycle against a frame-linear pixel index model.
module tb_vga_sync_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic a_vis, a_ls, a_fs, a_hs, a_vs, b_vis, b_ls, b_fs, b_hs, b_vs;
  int pa = -1, pb = -1;
  bit el = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .o_hpos(a_hpos), .o_vpos(a_vpos),
    .o_visible(a_vis), .o_line_strobe(a_ls), .o_frame_strobe(a_fs), .o_hsync(a_hs), .o_vsync(a_vs));

  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1),
                 .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .o_hpos(b_hpos), .o_vpos(b_vpos),
    .o_visible(b_vis), .o_line_strobe(b_ls), .o_frame_strobe(b_fs), .o_hsync(b_hs), .o_vsync(b_vs));

  // Expected outputs from the linear pixel index p within a frame (p<0: reset state).
  function automatic logic [24:0] model(int hv, int hf, int hsw, int hb, int vv, int vf, int vsw,
                                        int vb, bit sa, int p, bit e);
    int ht, h, v;
    bit hin, vin, ls;
    ht = hv + hf + hsw + hb;
    if (p < 0) return {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, ~sa, ~sa};
    h = p % ht;
    v = p / ht;
    hin = (h >= hv + hf) && (h < hv + hf + hsw);
    vin = (v >= vv + vf) && (v < vv + vf + vsw);
    ls = e && (h == 0);
    return {10'(h), 10'(v), (h < hv) && (v < vv), ls, ls && (v == vv), hin ? sa : ~sa, vin ? sa : ~sa};
  endfunction

  function automatic logic [49:0] expv();
    return {model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, pa, el),
            model(8, 2, 3, 2, 6, 1, 2, 3, 1'b1, pb, el)};
  endfunction

  wire [49:0] got = {a_hpos, a_vpos, a_vis, a_ls, a_fs, a_hs, a_vs,
                     b_hpos, b_vpos, b_vis, b_ls, b_fs, b_hs, b_vs};

  task automatic step(input bit r, input bit e);
    rst_n = r;
    en = e;
    @(posedge clk);
    if (!r) begin
      pa = -1; pb = -1; el = 1'b0;
    end else if (e) begin
      pa = (pa + 1) % 420000; pb = (pb + 1) % 180; el = 1'b1;
    end else el = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    total++;
    if (got !== expv()) begin bad++; $display("FAIL reset got=%h exp=%h", got, expv()); end
    total++;
    if ({a_hpos, a_vpos, a_vis, a_ls, a_fs, a_hs, a_vs, b_hs, b_vs} !== {20'd0, 5'b00011, 2'b00}) begin
      bad++; $display("FAIL reset_vals got a=(%0d,%0d) hs=%b vs=%b bhs=%b bvs=%b", a_hpos, a_vpos, a_hs, a_vs, b_hs, b_vs);
    end
  endtask

  task automatic test_line();
    int n = 0, first = -1, last = -1;
    for (int i = 1; i <= 801; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (got !== expv()) begin bad++; $display("FAIL line cyc=%0d got=%h exp=%h", i, got, expv()); end
      if (a_hs === 1'b0) begin n++; if (first < 0) first = int'(a_hpos); last = int'(a_hpos); end
      if (i == 1) begin
        total++;
        if ({a_hpos, a_vpos, a_vis, a_ls} !== {20'd0, 2'b11}) begin
          bad++; $display("FAIL first_pixel got=(%0d,%0d) vis=%b ls=%b exp=(0,0) 1 1", a_hpos, a_vpos, a_vis, a_ls);
        end
      end
      if (i == 640 || i == 641) begin
        total++;
        if (a_hpos !== 10'(i - 1) || a_vis !== (i == 640)) begin
          bad++; $display("FAIL vis_edge cyc=%0d got hpos=%0d vis=%b", i, a_hpos, a_vis);
        end
      end
      if (i == 801) begin
        total++;
        if (a_hpos !== 10'd0 || a_vpos !== 10'd1) begin
          bad++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", a_hpos, a_vpos);
        end
      end
    end
    total++;
    if (n != 96 || first != 656 || last != 751) begin
      bad++; $display("FAIL hsync_window got n=%0d %0d..%0d exp n=96 656..751", n, first, last);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (got !== expv() || a_ls !== 1'b0 || a_hpos !== 10'd0 || a_vpos !== 10'd1) begin
        bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, got, expv());
      end
    end
    step(1'b1, 1'b1);
    total++;
    if (a_hpos !== 10'd1 || a_ls !== 1'b0 || got !== expv()) begin
      bad++; $display("FAIL resume got hpos=%0d ls=%b exp hpos=1 ls=0", a_hpos, a_ls);
    end
  endtask

  task automatic test_midreset();
    step(1'b0, 1'b1);
    for (int i = 0; i < 301; i++) step(1'b1, 1'b1);
    total++;
    if (a_hpos !== 10'd300 || got !== expv()) begin bad++; $display("FAIL pre_reset got hpos=%0d exp 300", a_hpos); end
    step(1'b0, 1'b1);
    total++;
    if (got !== expv() || a_hpos !== 10'd0 || a_vis !== 1'b0 || a_hs !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=%h exp=%h", got, expv());
    end
    step(1'b1, 1'b1);
    total++;
    if ({a_hpos, a_vpos, a_vis} !== {20'd0, 1'b1} || got !== expv()) begin
      bad++; $display("FAIL post_reset got=(%0d,%0d) vis=%b exp=(0,0) 1", a_hpos, a_vpos, a_vis);
    end
  endtask

  task automatic test_frame();
    int fcnt = 0, fprev = -1, vs_on = 0, wraps = 0;
    logic [9:0] ph, pv;
    step(1'b0, 1'b1);
    for (int i = 1; i <= 400; i++) begin
      ph = b_hpos; pv = b_vpos;
      step(1'b1, 1'b1);
      total++;
      if (got !== expv()) begin bad++; $display("FAIL frame cyc=%0d got=%h exp=%h", i, got, expv()); end
      if (b_vs === 1'b1) vs_on++;
      if (i > 1 && ph == 10'd14 && pv == 10'd11) begin
        wraps++;
        total++;
        if (b_hpos !== 10'd0 || b_vpos !== 10'd0) begin bad++; $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", b_hpos, b_vpos); end
      end
      if (b_fs === 1'b1) begin
        fcnt++;
        if (fprev >= 0) begin
          total++;
          if (i - fprev != 180) begin bad++; $display("FAIL frame_spacing got=%0d exp=180", i - fprev); end
        end
        fprev = i;
      end
    end
    total++;
    if (fcnt != 2 || wraps != 2 || vs_on != 60) begin
      bad++; $display("FAIL frame_counts got fs=%0d wraps=%0d vs=%0d exp 2 2 60", fcnt, wraps, vs_on);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20000; i++) begin
      step(($urandom % 600) != 0, ($urandom % 4) != 0);
      total++;
      if (got !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_stall();
    test_midreset();
    test_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
